// File: rtl/mix_columns_serial.sv
// Forward AES MixColumns, one 32-bit column per cycle through a single shared
// column multiplier; bypass passes columns through unchanged for the final round.
module mix_columns_serial (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         bypass,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  // Handshake: start is sampled on a rising edge only in IDLE or FIN; busy is
  // high for the four column cycles; done pulses for exactly one cycle when out
  // is complete. out is only meaningful while done=1 or while idle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] src_q, src_d;
  logic         byp_q, byp_d;
  logic [127:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  col_in;
  logic [31:0]  col_mc;
  logic [31:0]  col_res;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mc_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    mc_col = {d0 ^ d1 ^ a1 ^ a2 ^ a3,
              a0 ^ d1 ^ d2 ^ a2 ^ a3,
              a0 ^ a1 ^ d2 ^ d3 ^ a3,
              d0 ^ a0 ^ a1 ^ a2 ^ d3};
  endfunction

  // Single multiplier: the active column is steered in by col_q.
  always_comb begin
    col_in = src_q[127:96];
    case (col_q)
      2'd0:    col_in = src_q[127:96];
      2'd1:    col_in = src_q[95:64];
      2'd2:    col_in = src_q[63:32];
      default: col_in = src_q[31:0];
    endcase
  end

  assign col_mc  = mc_col(col_in);
  assign col_res = byp_q ? col_in : col_mc;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    src_d   = src_q;
    byp_d   = byp_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = in;
          byp_d   = bypass;
          col_d   = 2'd0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        case (col_q)
          2'd0:    out_d[127:96] = col_res;
          2'd1:    out_d[95:64]  = col_res;
          2'd2:    out_d[63:32]  = col_res;
          default: out_d[31:0]   = col_res;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        done_d  = 1'b0;
        state_d = IDLE;
        // Accepting here gives back-to-back blocks every five cycles.
        if (start) begin
          src_d   = in;
          byp_d   = bypass;
          col_d   = 2'd0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        col_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      src_q   <= 128'h0;
      byp_q   <= 1'b0;
      out_q   <= 128'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      src_q   <= src_d;
      byp_q   <= byp_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mix_columns_serial.sv
// Self-checking bench for mix_columns_serial against a matrix-product model of
// MixColumns and its inverse over GF(2^8).
module tb_mix_columns_serial;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         bypass;
  logic [127:0] in;
  logic [127:0] out;
  logic         busy;
  logic         done;

  int checks;
  int errors;
  logic [127:0] last_out;
  logic [127:0] exp_q[$];

  localparam logic [127:0] FWD_M = 128'h02030101_01020301_01010203_03010102;
  localparam logic [127:0] INV_M = 128'h0e0b0d09_090e0b0d_0d090e0b_0b0d090e;

  mix_columns_serial dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bypass  (bypass),
    .in      (in),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: generic GF(2^8) multiply and 4x4 matrix times each column
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] p;
    p = 8'h00;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] apply_matrix(input logic [127:0] s, input logic [127:0] m);
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(m[127-8*(4*row+j) -: 8], s[127-32*c-8*j -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
    return byp ? s : apply_matrix(s, FWD_M);
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    bypass  = 1'b0;
    in      = '0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    last_out = '0;
  endtask

  // One block with full timing checks; start/in/bypass are scrambled while
  // running to confirm they are ignored.
  task automatic run_block(input logic [127:0] data, input logic byp,
                           input logic [127:0] expv, input string name);
    logic [127:0] partial;
    @(negedge clk);
    start = 1'b1; in = data; bypass = byp;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start  = (k < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      in     = {$urandom, $urandom, $urandom, $urandom};
      bypass = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++)
        partial[127-32*c -: 32] = (c < k) ? expv[127-32*c -: 32] : last_out[127-32*c -: 32];
      checks++;
      if (out !== partial) begin
        errors++;
        $display("FAIL %s out after E%0d: got %h required %h", name, k, out, partial);
      end
      checks++;
      if (busy !== (k < 4) || done !== (k == 4)) begin
        errors++;
        $display("FAIL %s flags after E%0d: busy=%b done=%b required busy=%b done=%b",
                 name, k, busy, done, (k < 4), (k == 4));
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== expv) begin
      errors++;
      $display("FAIL %s after FIN: done=%b busy=%b out=%h required 0 0 %h", name, done, busy, out, expv);
    end
    last_out = expv;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; bypass = 1'b0; in = '0;
    #2;
    checks++;
    if (out !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h busy=%b done=%b required 0 0 0", out, busy, done);
    end
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    last_out = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: out=%h busy=%b done=%b required 0 0 0", out, busy, done);
    end
  endtask

  task automatic test_fixed_points();
    logic [127:0] d;
    d = 128'hc6c6c6c6_01010101_d4d4d4d5_2d26314c;
    checks++;
    if (model(d, 1'b0) !== 128'hc6c6c6c6_01010101_d5d5d7d6_4d7ebdf8) begin
      errors++;
      $display("FAIL model_fixed: got %h", model(d, 1'b0));
    end
    run_block(d, 1'b0, 128'hc6c6c6c6_01010101_d5d5d7d6_4d7ebdf8, "fixed_points");
  endtask

  task automatic test_fips();
    run_block(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0,
              128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, "fips197");
  endtask

  task automatic test_bypass();
    run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
              128'h00112233_44556677_8899aabb_ccddeeff, "bypass");
    for (int i = 0; i < 4; i++) begin
      logic [127:0] d;
      logic         b;
      d = {$urandom, $urandom, $urandom, $urandom};
      b = 1'($urandom_range(0, 1));
      run_block(d, b, model(d, b), "random_block");
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; bypass = 1'b0; in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: out=%h busy=%b done=%b required 0 0 0", out, busy, done);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    last_out = '0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume: out=%h busy=%b done=%b required 0 0 0", out, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic         prev_done;
    logic [127:0] got_exp;
    int           accepts;
    int           dones;
    prev_done = 1'b0;
    accepts   = 0;
    dones     = 0;
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start  = 1'b1;
      in     = {$urandom, $urandom, $urandom, $urandom};
      bypass = 1'($urandom_range(0, 1));
      // from idle with start held, a new block is taken every fifth edge
      if (i % 5 == 0) begin
        exp_q.push_back(model(in, bypass));
        accepts++;
      end
      @(posedge clk); #1;
      checks++;
      if (done !== (i % 5 == 4) || busy !== (i % 5 != 4)) begin
        errors++;
        $display("FAIL b2b_flags edge %0d: done=%b busy=%b required done=%b busy=%b",
                 i, done, busy, (i % 5 == 4), (i % 5 != 4));
      end
      checks++;
      if (prev_done === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL b2b_double_done edge %0d: done=1 required 0", i);
      end
      prev_done = done;
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious_done edge %0d: queue empty", i);
        end else begin
          got_exp = exp_q.pop_front();
          if (out !== got_exp) begin
            errors++;
            $display("FAIL b2b_result edge %0d: got %h required %h", i, out, got_exp);
          end
          last_out = got_exp;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dones != accepts || exp_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: dones=%0d accepts=%0d pending=%0d busy=%b done=%b",
               dones, accepts, exp_q.size(), busy, done);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] d;
    int accepts;
    int dones;
    int bad;
    bit got;
    accepts = 0;
    dones   = 0;
    bad     = 0;
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      start = 1'b1; bypass = 1'b0; in = d;
      @(posedge clk);
      accepts++;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(posedge clk); #1;
        if (done === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL round_trip_timeout block %0d: no done within 10 cycles", n);
      end else begin
        dones++;
        if (apply_matrix(out, INV_M) !== d) begin
          errors++;
          bad++;
          if (bad <= 5)
            $display("FAIL round_trip block %0d: recovered %h required %h",
                     n, apply_matrix(out, INV_M), d);
        end
      end
    end
    checks++;
    if (dones != accepts) begin
      errors++;
      $display("FAIL round_trip_count: dones=%0d required %0d", dones, accepts);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fixed_points();
    test_fips();
    test_bypass();
    test_reset_mid_run();
    test_back_to_back();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
